seq_queued: RTL and testbench

//  Next-generation calculator sequencer. A FIFO buffers incoming instructions, which then execute

---
 rtl/seq_pkg.sv | 62 ++++++
 rtl/seq_fifo.sv | 56 +++++
 rtl/seq_queued.sv | 158 +++++++++++++++
 tb/tb_seq_queued.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the queued calculator sequencer:
// opcodes, FSM state encoding and instruction field helpers.
package seq_pkg;

  localparam int SEQ_OP_PUSH = 0;
  localparam int SEQ_OP_ADD  = 1;
  localparam int SEQ_OP_MULT = 2;
  localparam int SEQ_OP_SEND = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_GUARD = 2'd2
  } seq_state_e;

  function automatic logic [31:0] inst_field(
    input logic [31:0] inst,
    input int unsigned lsb,
    input int unsigned w
  );
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (inst >> lsb) & mask;
  endfunction

  function automatic logic [31:0] inst_op(
    input logic [31:0] inst,
    input int unsigned op_w,
    input int unsigned rn_w
  );
    return inst_field(inst, 3 * rn_w, op_w);
  endfunction

  function automatic logic [31:0] inst_ra(
    input logic [31:0] inst,
    input int unsigned rn_w
  );
    return inst_field(inst, 2 * rn_w, rn_w);
  endfunction

  function automatic logic [31:0] inst_rb(
    input logic [31:0] inst,
    input int unsigned rn_w
  );
    return inst_field(inst, rn_w, rn_w);
  endfunction

  function automatic logic [31:0] inst_rc(
    input logic [31:0] inst,
    input int unsigned rn_w
  );
    return inst_field(inst, 0, rn_w);
  endfunction

  function automatic logic [31:0] inst_imm(
    input logic [31:0] inst,
    input int unsigned rn_w
  );
    return inst_field(inst, 0, 2 * rn_w);
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Instruction FIFO for the sequencer.
// Power-of-two depth, synchronous reset, show-ahead read.
module seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr & ~full;
  assign do_rd   = rd & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_queued.sv
// Queued calculator sequencer: FIFO-buffered push/add/mult/send
// against a small register file, feeding a UART transmitter.
module seq_queued
  import seq_pkg::*;
#(
  parameter int DP_WIDTH   = 8,
  parameter int RN_WIDTH   = 2,
  parameter int OP_WIDTH   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TX_GUARD   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [OP_WIDTH+3*RN_WIDTH-1:0] i_inst,
  input  logic                           i_inst_valid,
  output logic                           o_inst_ready,
  input  logic                           i_send_valid,
  input  logic [RN_WIDTH-1:0]            i_send_sel,
  output logic                           o_send_ready,
  output logic [DP_WIDTH-1:0]            o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_busy,
  output logic                           o_idle,
  output logic                           o_ovf
);

  localparam int IN_WIDTH = OP_WIDTH + 3 * RN_WIDTH;
  localparam int IM_WIDTH = 2 * RN_WIDTH;
  localparam int NREG     = 2 ** RN_WIDTH;
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int GW       = (TX_GUARD > 1) ? $clog2(TX_GUARD) : 1;

  logic [IN_WIDTH-1:0]   head;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  logic [OP_WIDTH-1:0]   op;
  logic [RN_WIDTH-1:0]   ra;
  logic [RN_WIDTH-1:0]   rb;
  logic [RN_WIDTH-1:0]   rc;
  logic [RN_WIDTH-1:0]   send_idx;
  logic [IM_WIDTH-1:0]   imm;

  logic [DP_WIDTH-1:0]   regs [NREG];
  logic [DP_WIDTH-1:0]   a;
  logic [DP_WIDTH-1:0]   b;
  logic [DP_WIDTH:0]     sum;
  logic [2*DP_WIDTH-1:0] prod;

  seq_state_e            state;
  logic [GW-1:0]         gcnt;
  logic                  active;
  logic                  is_send;
  logic                  alu_go;
  logic                  q_send;
  logic                  d_send;
  logic                  more;

  seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IN_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (push),
    .wr_data (i_inst),
    .rd      (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign op  = OP_WIDTH'(inst_op(32'(head), OP_WIDTH, RN_WIDTH));
  assign ra  = RN_WIDTH'(inst_ra(32'(head), RN_WIDTH));
  assign rb  = RN_WIDTH'(inst_rb(32'(head), RN_WIDTH));
  assign rc  = RN_WIDTH'(inst_rc(32'(head), RN_WIDTH));
  assign imm = IM_WIDTH'(inst_imm(32'(head), RN_WIDTH));

  assign o_inst_ready = ~full;
  assign push         = i_inst_valid & ~full;

  // IDLE executes a freshly queued head at once to keep the one-cycle latency
  assign active  = (state == ST_IDLE || state == ST_EXEC) & ~empty;
  assign is_send = (op == OP_WIDTH'(SEQ_OP_SEND));
  assign alu_go  = active & ~is_send;
  assign q_send  = active & is_send & ~i_tx_busy;

  assign o_send_ready = i_send_valid & (state == ST_IDLE) & empty
                      & ~i_tx_busy & ~i_inst_valid;
  assign d_send       = o_send_ready;

  assign pop      = alu_go | q_send;
  assign more     = (count + CW'(push) - CW'(pop)) != '0;
  assign send_idx = q_send ? ra : i_send_sel;
  assign o_idle   = (state == ST_IDLE) & empty;

  assign a    = regs[ra];
  assign b    = regs[rb];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = (2*DP_WIDTH)'(a) * (2*DP_WIDTH)'(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gcnt       <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_ovf      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      o_tx_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_EXEC: begin
          if (alu_go) begin
            unique case (1'b1)
              op == OP_WIDTH'(SEQ_OP_PUSH): begin
                regs[ra] <= DP_WIDTH'(imm);
              end
              op == OP_WIDTH'(SEQ_OP_ADD): begin
                regs[rc] <= sum[DP_WIDTH-1:0];
                if (sum[DP_WIDTH]) o_ovf <= 1'b1;
              end
              op == OP_WIDTH'(SEQ_OP_MULT): begin
                regs[rc] <= prod[DP_WIDTH-1:0];
                if (|prod[2*DP_WIDTH-1:DP_WIDTH]) o_ovf <= 1'b1;
              end
              default: ;
            endcase
            state <= more ? ST_EXEC : ST_IDLE;
          end else if (q_send || d_send) begin
            o_tx_data  <= regs[send_idx];
            o_tx_valid <= 1'b1;
            gcnt       <= '0;
            state      <= ST_GUARD;
          end else begin
            state <= empty ? ST_IDLE : ST_EXEC;
          end
        end
        ST_GUARD: begin
          // UART busy lags the strobe; ignore its low level meanwhile
          if (gcnt == GW'(TX_GUARD - 1)) begin
            state <= more ? ST_EXEC : ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_queued.sv
// Directed self-checking bench for seq_queued.
// Default parameters: 8-bit data, 4 regs, 4-deep FIFO, guard 1.
module tb_seq_queued;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_inst;
  logic       i_inst_valid;
  logic       o_inst_ready;
  logic       i_send_valid;
  logic [1:0] i_send_sel;
  logic       o_send_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_busy;
  logic       o_idle;
  logic       o_ovf;

  always #5 clk = ~clk;

  seq_queued dut (
    .clk          (clk),
    .rst          (rst),
    .i_inst       (i_inst),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .i_send_valid (i_send_valid),
    .i_send_sel   (i_send_sel),
    .o_send_ready (o_send_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_busy    (i_tx_busy),
    .o_idle       (o_idle),
    .o_ovf        (o_ovf)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] tx_q [$];
  int         tx_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (o_tx_valid) begin
      tx_q.push_back(o_tx_data);
      tx_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [1:0] op,
                                    input logic [1:0] ra,
                                    input logic [1:0] rb,
                                    input logic [1:0] rc);
    return {op, ra, rb, rc};
  endfunction

  task automatic put(input logic [7:0] ins);
    i_inst       = ins;
    i_inst_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (o_inst_ready) break;
      tick();
    end
    chk("inst_accept", 32'(o_inst_ready), 1);
    tick();
    i_inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (o_idle) break;
      tick();
    end
    chk("idle_reached", 32'(o_idle), 1);
  endtask

  function automatic logic [7:0] tx_at(input int idx);
    logic [7:0] d;
    d = 8'hxx;
    if (idx < tx_q.size()) d = tx_q[idx];
    return d;
  endfunction

  int base;
  int gap;
  int bad;

  initial begin
    rst          = 1'b1;
    i_inst       = '0;
    i_inst_valid = 1'b0;
    i_send_valid = 1'b0;
    i_send_sel   = '0;
    i_tx_busy    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_idle", 32'(o_idle), 1);
    chk("rst_ready", 32'(o_inst_ready), 1);
    chk("rst_tx_valid", 32'(o_tx_valid), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    chk("rst_send_ready", 32'(o_send_ready), 0);

    // r0=3, r1=5, r2=r0+r1, send r2
    base = tx_q.size();
    put(mk(2'd0, 2'd0, 2'd0, 2'd3));
    chk("t1_busy_after_accept", 32'(o_idle), 0);
    put(mk(2'd0, 2'd1, 2'd1, 2'd1));
    put(mk(2'd1, 2'd0, 2'd1, 2'd2));
    put(mk(2'd3, 2'd2, 2'd0, 2'd0));
    wait_idle(30);
    chk("t1_count", 32'(tx_q.size() - base), 1);
    chk("t1_data", 32'(tx_at(base)), 8);

    // 15*15 -> r3, send r3, then r3+r3 wraps
    base = tx_q.size();
    put(mk(2'd0, 2'd0, 2'd3, 2'd3));
    put(mk(2'd0, 2'd1, 2'd3, 2'd3));
    put(mk(2'd2, 2'd0, 2'd1, 2'd3));
    put(mk(2'd3, 2'd3, 2'd0, 2'd0));
    wait_idle(30);
    chk("t2_count", 32'(tx_q.size() - base), 1);
    chk("t2_data", 32'(tx_at(base)), 8'hE1);
    chk("t2_ovf_clear", 32'(o_ovf), 0);
    put(mk(2'd1, 2'd3, 2'd3, 2'd2));
    wait_idle(30);
    chk("t2_ovf_set", 32'(o_ovf), 1);

    // busy holds two queued sends
    i_tx_busy = 1'b1;
    put(mk(2'd0, 2'd0, 2'd0, 2'd1));
    put(mk(2'd0, 2'd1, 2'd0, 2'd2));
    put(mk(2'd3, 2'd0, 2'd0, 2'd0));
    put(mk(2'd3, 2'd1, 2'd0, 2'd0));
    base = tx_q.size();
    repeat (10) tick();
    chk("t3_no_strobe", 32'(tx_q.size() - base), 0);
    chk("t3_not_idle", 32'(o_idle), 0);
    i_tx_busy = 1'b0;
    wait_idle(40);
    chk("t3_count", 32'(tx_q.size() - base), 2);
    chk("t3_data0", 32'(tx_at(base)), 1);
    chk("t3_data1", 32'(tx_at(base + 1)), 2);
    gap = (tx_cyc.size() > base + 1) ? tx_cyc[base+1] - tx_cyc[base] : 0;
    chk("t3_gap_ok", 32'(gap >= 2), 1);

    // fill FIFO behind a stalled head send
    i_tx_busy = 1'b1;
    base = tx_q.size();
    put(mk(2'd3, 2'd0, 2'd0, 2'd0));
    put(mk(2'd0, 2'd1, 2'd1, 2'd3));
    put(mk(2'd0, 2'd2, 2'd2, 2'd1));
    put(mk(2'd1, 2'd1, 2'd2, 2'd3));
    chk("t4_full_ready", 32'(o_inst_ready), 0);
    i_inst       = mk(2'd3, 2'd3, 2'd0, 2'd0);
    i_inst_valid = 1'b1;
    repeat (3) tick();
    chk("t4_still_full", 32'(o_inst_ready), 0);
    chk("t4_no_strobe", 32'(tx_q.size() - base), 0);
    i_tx_busy = 1'b0;
    put(mk(2'd3, 2'd3, 2'd0, 2'd0));
    put(mk(2'd3, 2'd1, 2'd0, 2'd0));
    wait_idle(60);
    chk("t4_count", 32'(tx_q.size() - base), 3);
    chk("t4_data0", 32'(tx_at(base)), 1);
    chk("t4_data1", 32'(tx_at(base + 1)), 16);
    chk("t4_data2", 32'(tx_at(base + 2)), 7);

    // direct send r1 and its gating
    wait_idle(20);
    i_send_valid = 1'b1;
    i_send_sel   = 2'd1;
    #1;
    chk("t5_send_ready", 32'(o_send_ready), 1);
    tick();
    i_send_valid = 1'b0;
    chk("t5_tx_valid", 32'(o_tx_valid), 1);
    chk("t5_tx_data", 32'(o_tx_data), 7);
    wait_idle(20);
    i_send_valid = 1'b1;
    i_inst_valid = 1'b1;
    #1;
    chk("t5_ready_inst_prio", 32'(o_send_ready), 0);
    i_inst_valid = 1'b0;
    i_tx_busy    = 1'b1;
    #1;
    chk("t5_ready_busy", 32'(o_send_ready), 0);
    i_tx_busy    = 1'b0;
    i_send_valid = 1'b0;

    // reset during GUARD with three entries queued
    i_tx_busy = 1'b1;
    put(mk(2'd3, 2'd1, 2'd0, 2'd0));
    put(mk(2'd0, 2'd0, 2'd2, 2'd1));
    put(mk(2'd0, 2'd2, 2'd2, 2'd1));
    put(mk(2'd0, 2'd3, 2'd2, 2'd1));
    chk("t6_full", 32'(o_inst_ready), 0);
    base = tx_q.size();
    i_tx_busy = 1'b0;
    tick();
    chk("t6_issue", 32'(o_tx_valid), 1);
    chk("t6_issue_data", 32'(o_tx_data), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_idle", 32'(o_idle), 1);
    chk("t6_tx_valid", 32'(o_tx_valid), 0);
    chk("t6_ovf", 32'(o_ovf), 0);
    chk("t6_ready", 32'(o_inst_ready), 1);
    repeat (10) tick();
    chk("t6_no_more_tx", 32'(tx_q.size() - base), 1);
    for (int r = 0; r < 4; r++) begin
      wait_idle(20);
      i_send_valid = 1'b1;
      i_send_sel   = 2'(r);
      tick();
      i_send_valid = 1'b0;
      chk("t6_reg_zero_strobe", 32'(o_tx_valid), 1);
      chk("t6_reg_zero", 32'(o_tx_data), 0);
    end
    wait_idle(20);

    bad = 0;
    for (int i = 1; i < tx_cyc.size(); i++) begin
      if (tx_cyc[i] - tx_cyc[i-1] < 2) bad++;
    end
    chk("tx_spacing", 32'(bad), 0);
    chk("tx_total", 32'(tx_q.size()), 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
